bias_loader: RTL and testbench

Synthesizable bias-fetch stage that sits directly downstream of the byte-serial bias memory. On a start pulse it pulls NUM_BIAS bytes over the four-phase readM/ready handshake and stores them in an internal register file. The LSTM datapath reads them through a combinational read port. It flags completion with a one-cycle done pulse and a sticky loaded flag.

---
 rtl/bias_loader_if.sv | 21 ++
 rtl/bias_loader.sv | 152 +++++++++++++++
 tb/tb_bias_loader.sv | 397 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_loader_if.sv
// Four-phase byte-serial bus between the bias memory and the bias loader.
// The loader is the master: it raises readM, the memory answers with ready and mem_data.
interface bias_loader_if #(
    parameter int unsigned DATA_W = 8
);
    logic              readM;
    logic              ready;
    logic [DATA_W-1:0] mem_data;

    modport master (
        output readM,
        input  ready,
        input  mem_data
    );

    modport slave (
        input  readM,
        output ready,
        output mem_data
    );
endinterface

// File: rtl/bias_loader.sv
// Bias-fetch stage: pulls NUM_BIAS bytes over a four-phase readM/ready handshake
// into a local register file and exposes them through a combinational read port.
module bias_loader #(
    parameter int unsigned NUM_BIAS = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DATA_W   = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    bias_loader_if.master       mem,
    output logic                busy,
    output logic                done,
    output logic                loaded,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]   rd_data
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_BIAS - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   index_q, index_d;
    logic                readm_q, readm_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                loaded_q, loaded_d;
    logic                ready_meta_q, ready_s_q;
    logic                bias_we;
    logic [DATA_W-1:0]   bias_q [NUM_BIAS];
    logic [DATA_W-1:0]   bias_d [NUM_BIAS];
    logic [31:0]         rd_idx;

    // ready comes from the memory's own timing domain; only ready_s_q is used below.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_meta_q <= 1'b0;
            ready_s_q    <= 1'b0;
        end else begin
            ready_meta_q <= mem.ready;
            ready_s_q    <= ready_meta_q;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            index_q  <= '0;
            readm_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            loaded_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            readm_q  <= readm_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            loaded_q <= loaded_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        loaded_d = loaded_q;
        bias_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    loaded_d = 1'b0;
                    index_d  = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (ready_s_q) begin
                    bias_we = 1'b1;
                    state_d = REL;
                end
            end
            REL: begin
                if (!ready_s_q) begin
                    if (index_q == LAST_IDX) begin
                        loaded_d = 1'b1;
                        state_d  = DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = REQ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Outputs are registered from the next state so they line up with state_q.
        readm_d = (state_d == REQ);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_comb begin
        bias_d = bias_q;
        if (bias_we) begin
            bias_d[index_q] = mem.mem_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < NUM_BIAS; i++) begin
                bias_q[i] <= '0;
            end
        end else begin
            bias_q <= bias_d;
        end
    end

    // Widen before comparing so the range check stays meaningful for any NUM_BIAS.
    always_comb begin
        rd_idx  = 32'(rd_addr);
        rd_data = '0;
        if (rd_idx < NUM_BIAS) begin
            rd_data = bias_q[rd_addr];
        end
    end

    assign mem.readM = readm_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign loaded    = loaded_q;

    a_readm_only_in_req: assert property (
        @(posedge clk) disable iff (!resetn) readm_q == (state_q == REQ));

    a_index_in_range: assert property (
        @(posedge clk) disable iff (!resetn) index_q <= LAST_IDX);

    a_done_single_cycle: assert property (
        @(posedge clk) disable iff (!resetn) done_q |=> !done_q);

endmodule

// File: tb/tb_bias_loader.sv
// Self-checking bench for bias_loader: randomized four-phase memory responder,
// bus monitor and an array-based reference of the expected register file.
module tb_bias_loader;

    localparam int unsigned NB = 32;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       busy, done, loaded;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;

    bias_loader_if #(.DATA_W(8)) bus ();

    bias_loader #(
        .NUM_BIAS (32),
        .ADDR_W   (5),
        .DATA_W   (8)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .mem     (bus.master),
        .busy    (busy),
        .done    (done),
        .loaded  (loaded),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    logic [7:0] mem   [64];
    logic [7:0] model [NB];

    int mem_addr  = 0;
    int dmin      = 10;
    int dmax      = 10;
    int hold_byte = -1;
    int hold_len  = 0;

    int rise_cnt   = 0;
    int done_cnt   = 0;
    int viol       = 0;
    int busy_viol  = 0;
    int loaded_viol = 0;
    bit in_load    = 0;

    // Memory responder: delay, raise ready with data, wait for readM low, delay, drop ready.
    initial begin : responder
        int mst;
        int cnt;
        int hold;
        mst  = 0;
        cnt  = 0;
        hold = 0;
        bus.ready    = 1'b0;
        bus.mem_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!resetn) begin
                bus.ready = 1'b0;
                mst = 0;
            end else begin
                case (mst)
                    0: if (bus.readM) begin
                        cnt = $urandom_range(dmax, dmin);
                        mst = 1;
                    end
                    1: if (cnt <= 1) begin
                        bus.mem_data = mem[mem_addr % 64];
                        bus.ready    = 1'b1;
                        hold = (mem_addr == hold_byte) ? hold_len : 0;
                        mst  = 2;
                    end else begin
                        cnt--;
                    end
                    2: if (hold > 0) begin
                        hold--;
                    end else if (!bus.readM) begin
                        cnt = $urandom_range(dmax, dmin);
                        mst = 3;
                    end
                    default: if (cnt <= 1) begin
                        bus.ready = 1'b0;
                        mem_addr++;
                        mst = 0;
                    end else begin
                        cnt--;
                    end
                endcase
            end
        end
    end

    // Bus monitor: counts fetches and done pulses, records protocol and status violations.
    initial begin : monitor
        logic prev_readm;
        prev_readm = 1'b0;
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (bus.readM && !prev_readm) begin
                    rise_cnt++;
                    if (bus.ready) viol++;
                end
                if (!bus.readM && prev_readm && !bus.ready) viol++;
                if (done) done_cnt++;
                if (in_load && !busy) busy_viol++;
                if (in_load && loaded && !done) loaded_viol++;
            end
            prev_readm = bus.readM;
        end
    end

    function automatic logic [7:0] exp_rd(int a);
        return (a < int'(NB)) ? model[a] : 8'h00;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < int'(NB); i++) model[i] = mem[i];
    endtask

    task automatic start_load();
        mem_addr = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        start   = 1'b0;
        rd_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.readM !== 1'b0) $display("FAIL reset_readM got %b want 0", bus.readM); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
        total++; if (loaded !== 1'b0) $display("FAIL reset_loaded got %b want 0", loaded); else passed++;
        for (int a = 0; a < int'(NB); a++) begin
            rd_addr = 5'(a);
            #1;
            total++;
            if (rd_data !== 8'h00) $display("FAIL reset_rd[%0d] got %h want 00", a, rd_data); else passed++;
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic_load();
        int base_r;
        int base_d;
        bit ok;
        for (int i = 0; i < 64; i++) mem[i] = 8'h80;
        for (int i = 0; i < int'(NB); i++) model[i] = 8'h80;
        dmin = 10;
        dmax = 10;
        base_r = rise_cnt;
        base_d = done_cnt;
        start_load();
        total++; if (bus.readM !== 1'b1) $display("FAIL basic_readM_after_start got %b want 1", bus.readM); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL basic_busy_after_start got %b want 1", busy); else passed++;
        in_load = 1'b1;
        wait_done(20000, ok);
        in_load = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL basic_done_timeout got %b want 1", ok); else passed++;
        total++; if (rise_cnt - base_r !== 32) $display("FAIL basic_fetches got %0d want 32", rise_cnt - base_r); else passed++;
        total++; if (loaded !== 1'b1) $display("FAIL basic_loaded_with_done got %b want 1", loaded); else passed++;
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL basic_busy_after_done got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL basic_done_width got %b want 0", done); else passed++;
        total++; if (loaded !== 1'b1) $display("FAIL basic_loaded_sticky got %b want 1", loaded); else passed++;
        total++; if (done_cnt - base_d !== 1) $display("FAIL basic_done_count got %0d want 1", done_cnt - base_d); else passed++;
        for (int a = 0; a < int'(NB); a++) begin
            rd_addr = 5'(a);
            #1;
            total++;
            if (rd_data !== exp_rd(a)) $display("FAIL basic_rd[%0d] got %h want %h", a, rd_data, exp_rd(a)); else passed++;
        end
    endtask

    task automatic test_pattern_load();
        bit ok;
        for (int i = 0; i < 64; i++) mem[i] = 8'(i) ^ 8'h5A;
        for (int i = 0; i < int'(NB); i++) model[i] = mem[i];
        dmin = 2;
        dmax = 12;
        start_load();
        wait_done(20000, ok);
        rd_addr = 5'd31;
        #1;
        total++; if (ok !== 1'b1) $display("FAIL pattern_done_timeout got %b want 1", ok); else passed++;
        total++; if (rd_data !== 8'h45) $display("FAIL pattern_rd31_at_done got %h want 45", rd_data); else passed++;
        rd_addr = 5'd0;
        #1;
        total++; if (rd_data !== 8'h5A) $display("FAIL pattern_rd0 got %h want 5a", rd_data); else passed++;
        rd_addr = 5'd1;
        #1;
        total++; if (rd_data !== 8'h5B) $display("FAIL pattern_rd1 got %h want 5b", rd_data); else passed++;
        for (int a = 0; a < int'(NB); a++) begin
            rd_addr = 5'(a);
            #1;
            total++;
            if (rd_data !== exp_rd(a)) $display("FAIL pattern_rd[%0d] got %h want %h", a, rd_data, exp_rd(a)); else passed++;
        end
    endtask

    task automatic test_handshake();
        bit ok;
        fill_random();
        dmin = 1;
        dmax = 15;
        start_load();
        in_load = 1'b1;
        wait_done(20000, ok);
        in_load = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL hs_done_timeout got %b want 1", ok); else passed++;
        total++; if (viol !== 0) $display("FAIL hs_protocol_violations got %0d want 0", viol); else passed++;
        total++; if (busy_viol !== 0) $display("FAIL hs_busy_low_in_load got %0d want 0", busy_viol); else passed++;
        total++; if (loaded_viol !== 0) $display("FAIL hs_loaded_high_in_load got %0d want 0", loaded_viol); else passed++;
    endtask

    task automatic test_start_during_load();
        int base_r;
        int base_d;
        bit ok;
        fill_random();
        dmin = 3;
        dmax = 10;
        base_r = rise_cnt;
        base_d = done_cnt;
        start_load();
        ok = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (rise_cnt - base_r >= 11) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (ok !== 1'b1) $display("FAIL sdl_reach_byte10 got %b want 1", ok); else passed++;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(20000, ok);
        total++; if (ok !== 1'b1) $display("FAIL sdl_done_timeout got %b want 1", ok); else passed++;
        repeat (4) @(negedge clk);
        total++; if (rise_cnt - base_r !== 32) $display("FAIL sdl_fetches got %0d want 32", rise_cnt - base_r); else passed++;
        total++; if (done_cnt - base_d !== 1) $display("FAIL sdl_done_count got %0d want 1", done_cnt - base_d); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL sdl_no_restart got %b want 0", busy); else passed++;
        for (int a = 0; a < int'(NB); a++) begin
            rd_addr = 5'(a);
            #1;
            total++;
            if (rd_data !== exp_rd(a)) $display("FAIL sdl_rd[%0d] got %h want %h", a, rd_data, exp_rd(a)); else passed++;
        end

        // start held high through DONE chains a second load
        fill_random();
        base_r = rise_cnt;
        base_d = done_cnt;
        mem_addr = 0;
        @(posedge clk);
        #1 start = 1'b1;
        wait_done(20000, ok);
        total++; if (ok !== 1'b1) $display("FAIL held_first_done got %b want 1", ok); else passed++;
        mem_addr = 0;
        fill_random();
        @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL held_idle_busy got %b want 0", busy); else passed++;
        total++; if (loaded !== 1'b1) $display("FAIL held_idle_loaded got %b want 1", loaded); else passed++;
        @(posedge clk);
        #1 start = 1'b0;
        total++; if (bus.readM !== 1'b1) $display("FAIL held_second_readM got %b want 1", bus.readM); else passed++;
        total++; if (loaded !== 1'b0) $display("FAIL held_loaded_drops got %b want 0", loaded); else passed++;
        in_load = 1'b1;
        wait_done(20000, ok);
        in_load = 1'b0;
        total++; if (ok !== 1'b1) $display("FAIL held_second_done got %b want 1", ok); else passed++;
        total++; if (rise_cnt - base_r !== 64) $display("FAIL held_fetches got %0d want 64", rise_cnt - base_r); else passed++;
        total++; if (done_cnt - base_d !== 2) $display("FAIL held_done_count got %0d want 2", done_cnt - base_d); else passed++;
        for (int a = 0; a < int'(NB); a++) begin
            rd_addr = 5'(a);
            #1;
            total++;
            if (rd_data !== exp_rd(a)) $display("FAIL held_rd[%0d] got %h want %h", a, rd_data, exp_rd(a)); else passed++;
        end
    endtask

    task automatic test_reset_mid_load();
        int base_r;
        bit ok;
        fill_random();
        dmin = 2;
        dmax = 8;
        base_r = rise_cnt;
        start_load();
        ok = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (rise_cnt - base_r == 16 && bus.readM) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (ok !== 1'b1) $display("FAIL rml_reach_byte15 got %b want 1", ok); else passed++;
        #2 resetn = 1'b0;
        #1;
        total++; if (bus.readM !== 1'b0) $display("FAIL rml_readM_async got %b want 0", bus.readM); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL rml_busy got %b want 0", busy); else passed++;
        total++; if (loaded !== 1'b0) $display("FAIL rml_loaded got %b want 0", loaded); else passed++;
        for (int a = 0; a < int'(NB); a++) begin
            rd_addr = 5'(a);
            #1;
            total++;
            if (rd_data !== 8'h00) $display("FAIL rml_rd[%0d] got %h want 00", a, rd_data); else passed++;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        fill_random();
        base_r = rise_cnt;
        start_load();
        wait_done(20000, ok);
        total++; if (ok !== 1'b1) $display("FAIL rml_reload_done got %b want 1", ok); else passed++;
        total++; if (rise_cnt - base_r !== 32) $display("FAIL rml_reload_fetches got %0d want 32", rise_cnt - base_r); else passed++;
        for (int a = 0; a < int'(NB); a++) begin
            rd_addr = 5'(a);
            #1;
            total++;
            if (rd_data !== exp_rd(a)) $display("FAIL rml_rd_reload[%0d] got %h want %h", a, rd_data, exp_rd(a)); else passed++;
        end
    endtask

    task automatic test_slow_memory();
        int base_r;
        int base_v;
        bit ok;
        fill_random();
        dmin = 1;
        dmax = 40;
        hold_byte = 5;
        hold_len  = 50;
        base_r = rise_cnt;
        base_v = viol;
        start_load();
        in_load = 1'b1;
        wait_done(40000, ok);
        in_load = 1'b0;
        hold_byte = -1;
        total++; if (ok !== 1'b1) $display("FAIL slow_done_timeout got %b want 1", ok); else passed++;
        total++; if (rise_cnt - base_r !== 32) $display("FAIL slow_fetches got %0d want 32", rise_cnt - base_r); else passed++;
        total++; if (viol - base_v !== 0) $display("FAIL slow_protocol got %0d want 0", viol - base_v); else passed++;
        total++; if (busy_viol !== 0) $display("FAIL slow_busy_low_in_load got %0d want 0", busy_viol); else passed++;
        for (int a = 0; a < int'(NB); a++) begin
            rd_addr = 5'(a);
            #1;
            total++;
            if (rd_data !== exp_rd(a)) $display("FAIL slow_rd[%0d] got %h want %h", a, rd_data, exp_rd(a)); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_pattern_load();
        test_handshake();
        test_start_during_load();
        test_reset_mid_load();
        test_slow_memory();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
